id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands and control each cycle.
- Applies EX/MEM and MEM/WB forwarding, then drives operand_a, operand_b and alu_control into the ALU.
- Handles stall and flush, and flags load-use hazards back to the hazard/control logic.

---
 rtl/id_ex_stage_if.sv | 67 ++++++
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode side and the ID/EX stage.
// The slave modport is the stage itself. The master modport is whatever drives decode and forwarding.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4
);
    logic                      stall;
    logic                      flush;
    logic                      id_valid;
    logic [DATA_WIDTH-1:0]     id_pc;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [ALU_CTRL_WIDTH-1:0] id_alu_control;
    logic                      id_alu_src;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      id_mem_write;
    logic                      id_mem_to_reg;
    logic                      id_branch;
    logic                      ex_mem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] ex_mem_rd;
    logic [DATA_WIDTH-1:0]     ex_mem_result;
    logic                      mem_wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] mem_wb_rd;
    logic [DATA_WIDTH-1:0]     mem_wb_result;
    logic [DATA_WIDTH-1:0]     operand_a;
    logic [DATA_WIDTH-1:0]     operand_b;
    logic [ALU_CTRL_WIDTH-1:0] alu_control;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [DATA_WIDTH-1:0]     ex_pc;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_valid;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_mem_write;
    logic                      ex_mem_to_reg;
    logic                      ex_branch;
    logic                      load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_control, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_branch,
               ex_mem_reg_write, ex_mem_rd, ex_mem_result,
               mem_wb_reg_write, mem_wb_rd, mem_wb_result,
        input  operand_a, operand_b, alu_control, store_data, ex_pc, ex_imm, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_control, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_branch,
               ex_mem_reg_write, ex_mem_rd, ex_mem_result,
               mem_wb_reg_write, mem_wb_rd, mem_wb_result,
        output operand_a, operand_b, alu_control, store_data, ex_pc, ex_imm, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding in front of the ALU.
// It also detects load-use hazards for the hazard unit.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic [DATA_WIDTH-1:0]     rs1_data_q;
    logic [DATA_WIDTH-1:0]     rs2_data_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_q;
    logic                      alu_src_q;
    logic                      reg_write_q;
    logic                      mem_read_q;
    logic                      mem_write_q;
    logic                      mem_to_reg_q;
    logic                      branch_q;

    logic [DATA_WIDTH-1:0]     fwd_a;
    logic [DATA_WIDTH-1:0]     fwd_b;

    // A flush loads the same all-zero bubble as reset, so both share one branch.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
        end else if (!bus.stall) begin
            valid_q      <= bus.id_valid;
            pc_q         <= bus.id_pc;
            rs1_data_q   <= bus.id_rs1_data;
            rs2_data_q   <= bus.id_rs2_data;
            imm_q        <= bus.id_imm;
            rs1_q        <= bus.id_rs1;
            rs2_q        <= bus.id_rs2;
            rd_q         <= bus.id_rd;
            alu_ctrl_q   <= bus.id_alu_control;
            alu_src_q    <= bus.id_alu_src;
            // An invalid decode slot becomes a bubble: its data is kept, but its side effects are masked.
            reg_write_q  <= bus.id_valid & bus.id_reg_write;
            mem_read_q   <= bus.id_valid & bus.id_mem_read;
            mem_write_q  <= bus.id_valid & bus.id_mem_write;
            mem_to_reg_q <= bus.id_valid & bus.id_mem_to_reg;
            branch_q     <= bus.id_valid & bus.id_branch;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB. A write to x0 is never forwarded.
    always_comb begin
        fwd_a = rs1_data_q;
        if (bus.ex_mem_reg_write && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == rs1_q))
            fwd_a = bus.ex_mem_result;
        else if (bus.mem_wb_reg_write && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == rs1_q))
            fwd_a = bus.mem_wb_result;
    end

    always_comb begin
        fwd_b = rs2_data_q;
        if (bus.ex_mem_reg_write && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == rs2_q))
            fwd_b = bus.ex_mem_result;
        else if (bus.mem_wb_reg_write && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == rs2_q))
            fwd_b = bus.mem_wb_result;
    end

    assign bus.operand_a     = fwd_a;
    assign bus.operand_b     = alu_src_q ? imm_q : fwd_b;
    assign bus.store_data    = fwd_b;
    assign bus.alu_control   = alu_ctrl_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_imm        = imm_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_reg_write  = reg_write_q;
    assign bus.ex_mem_read   = mem_read_q;
    assign bus.ex_mem_write  = mem_write_q;
    assign bus.ex_mem_to_reg = mem_to_reg_q;
    assign bus.ex_branch     = branch_q;

    assign bus.load_use_hazard = valid_q && mem_read_q && (rd_q != '0) &&
                                 ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A behavioural model of the stage contents is checked on every negedge.
// Hand-computed literal checks pin both the model and the design.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_CTRL_WIDTH(4)) bus ();

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_CTRL_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        valid;
        bit [31:0] pc, d1, d2, imm;
        bit [4:0]  rs1, rs2, rd;
        bit [3:0]  ctrl;
        bit        src, rw, mr, mw, m2r, br;
    } slot_t;

    slot_t m;
    bit    m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The newest producer that writes a nonzero matching register supplies the value.
    function automatic bit [31:0] forward(input bit [4:0] idx, input bit [31:0] own);
        bit        we  [2];
        bit [4:0]  dst [2];
        bit [31:0] val [2];
        we[0] = bus.ex_mem_reg_write; dst[0] = bus.ex_mem_rd; val[0] = bus.ex_mem_result;
        we[1] = bus.mem_wb_reg_write; dst[1] = bus.mem_wb_rd; val[1] = bus.mem_wb_result;
        for (int i = 0; i < 2; i++)
            if (we[i] && idx != 0 && dst[i] == idx) return val[i];
        return own;
    endfunction

    always @(posedge clk) begin
        if (rst || bus.flush) begin
            m = '{default: '0};
            m_known = 1'b1;
        end else if (!bus.stall) begin
            m.valid = bus.id_valid;
            m.pc = bus.id_pc; m.d1 = bus.id_rs1_data; m.d2 = bus.id_rs2_data; m.imm = bus.id_imm;
            m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
            m.ctrl = bus.id_alu_control; m.src = bus.id_alu_src;
            m.rw  = bus.id_valid ? bus.id_reg_write  : 1'b0;
            m.mr  = bus.id_valid ? bus.id_mem_read   : 1'b0;
            m.mw  = bus.id_valid ? bus.id_mem_write  : 1'b0;
            m.m2r = bus.id_valid ? bus.id_mem_to_reg : 1'b0;
            m.br  = bus.id_valid ? bus.id_branch     : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            bit [31:0] fa, fb;
            bit        haz;
            fa  = forward(m.rs1, m.d1);
            fb  = forward(m.rs2, m.d2);
            haz = m.valid && m.mr && m.rd != 0 && (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
            chk("m_operand_a",  bus.operand_a, fa);
            chk("m_operand_b",  bus.operand_b, m.src ? m.imm : fb);
            chk("m_store_data", bus.store_data, fb);
            chk("m_alu_control", {28'd0, bus.alu_control}, {28'd0, m.ctrl});
            chk("m_ex_pc",  bus.ex_pc, m.pc);
            chk("m_ex_imm", bus.ex_imm, m.imm);
            chk("m_ex_rd",  {27'd0, bus.ex_rd}, {27'd0, m.rd});
            chk("m_ctrl_bits",
                {25'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                 bus.ex_mem_to_reg, bus.ex_branch, bus.load_use_hazard},
                {25'd0, m.valid, m.rw, m.mr, m.mw, m.m2r, m.br, haz});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input bit v, input bit [31:0] pc, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit [4:0] rd, input bit [31:0] d1, input bit [31:0] d2,
                          input bit [31:0] imm, input bit [3:0] ctrl, input bit [5:0] cb);
        bus.id_valid = v; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_alu_control = ctrl;
        {bus.id_alu_src, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
         bus.id_mem_to_reg, bus.id_branch} = cb;
    endtask

    task automatic fwd_set(input bit we1, input bit [4:0] rd1, input bit [31:0] r1,
                           input bit we2, input bit [4:0] rd2, input bit [31:0] r2);
        bus.ex_mem_reg_write = we1; bus.ex_mem_rd = rd1; bus.ex_mem_result = r1;
        bus.mem_wb_reg_write = we2; bus.mem_wb_rd = rd2; bus.mem_wb_result = r2;
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        // cb = {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}
        id_set(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF, 32'hCAFEF00D, 32'h1234, 4'b0011, 6'b111111);
        fwd_set(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        cyc(); cyc();
        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_ctrl", {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                         bus.ex_mem_to_reg, bus.ex_branch}, 32'd0);
        chk("rst_alu_control", {28'd0, bus.alu_control}, 32'd0);
        chk("rst_operand_a", bus.operand_a, 32'd0);
        chk("rst_operand_b", bus.operand_b, 32'd0);
        rst = 1'b0;

        id_set(1, 32'h200, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h40, 4'b0001, 6'b010000);
        fwd_set(1, 5'd9, 32'h999, 1, 5'd10, 32'h1010);
        cyc();
        chk("load_operand_a", bus.operand_a, 32'd5);
        chk("load_operand_b", bus.operand_b, 32'd7);
        chk("load_alu_control", {28'd0, bus.alu_control}, 32'd1);
        chk("load_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("load_ex_pc", bus.ex_pc, 32'h200);

        id_set(1, 32'h204, 5'd3, 5'd5, 5'd6, 32'h11, 32'h55, 32'h0, 4'b0000, 6'b010000);
        fwd_set(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
        cyc();
        chk("prio_exmem", bus.operand_a, 32'hAA);
        chk("prio_no_hit_b", bus.operand_b, 32'h55);
        bus.ex_mem_reg_write = 1'b0;
        #1;
        chk("prio_memwb", bus.operand_a, 32'hBB);

        id_set(1, 32'h208, 5'd0, 5'd5, 5'd6, 32'h22, 32'h55, 32'h0, 4'b0000, 6'b010000);
        fwd_set(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
        cyc();
        chk("x0_no_forward", bus.operand_a, 32'h22);

        id_set(1, 32'h300, 5'd7, 5'd6, 5'd8, 32'h77, 32'h99, 32'hFFFFFFFC, 4'b0010, 6'b100100);
        fwd_set(0, 5'd6, 32'hEE, 1, 5'd6, 32'h10);
        cyc();
        chk("imm_operand_b", bus.operand_b, 32'hFFFFFFFC);
        chk("imm_store_data", bus.store_data, 32'h10);
        chk("imm_operand_a", bus.operand_a, 32'h77);
        chk("imm_mem_write", {31'd0, bus.ex_mem_write}, 32'd1);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_set(1, 32'h400 + i, 5'd1, 5'd2, 5'd4, i, i + 1, i, 4'b0100, 6'b011011);
            cyc();
            chk("stall_operand_b", bus.operand_b, 32'hFFFFFFFC);
            chk("stall_store_data", bus.store_data, 32'h10);
            chk("stall_ex_pc", bus.ex_pc, 32'h300);
            chk("stall_alu_control", {28'd0, bus.alu_control}, 32'd2);
        end
        bus.flush = 1'b1;
        cyc();
        chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_ex_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        chk("flush_ex_mem_write", {31'd0, bus.ex_mem_write}, 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        fwd_set(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        id_set(1, 32'h500, 5'd1, 5'd2, 5'd4, 32'h1, 32'h2, 32'h8, 4'b0000, 6'b111010);
        cyc();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd4;
        #1;
        chk("lu_rs2_hit", {31'd0, bus.load_use_hazard}, 32'd1);
        bus.id_rs1 = 5'd4; bus.id_rs2 = 5'd9;
        #1;
        chk("lu_rs1_hit", {31'd0, bus.load_use_hazard}, 32'd1);
        bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd9;
        #1;
        chk("lu_no_match", {31'd0, bus.load_use_hazard}, 32'd0);

        id_set(1, 32'h504, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'h8, 4'b0000, 6'b111010);
        cyc();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        #1;
        chk("lu_rd_x0", {31'd0, bus.load_use_hazard}, 32'd0);

        id_set(0, 32'h508, 5'd1, 5'd2, 5'd4, 32'h3, 32'h4, 32'h8, 4'b0000, 6'b111010);
        cyc();
        bus.id_rs2 = 5'd4;
        #1;
        chk("lu_bubble", {31'd0, bus.load_use_hazard}, 32'd0);
        chk("bubble_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
        chk("bubble_ex_rd", {27'd0, bus.ex_rd}, 32'd4);
        chk("bubble_data", bus.operand_a, 32'h3);

        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
